// File: rtl/player_state_fsm_pkg.sv
// Shared state codes, widths and direction decode for the player state machine.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package player_pkg;

    localparam int STATE_W = 4;
    localparam int FRAME_W = 7;
    localparam int SPEED_W = 4;

    localparam logic signed [SPEED_W-1:0] SPEED_MIN = 4'sb1000;

    typedef enum logic [STATE_W-1:0] {
        ST_LEVEL_1_BEGIN = 4'd0,
        ST_IDLE          = 4'd1,
        ST_RUN_R         = 4'd2,
        ST_RUN_L         = 4'd3,
        ST_JUMP          = 4'd4,
        ST_FALL          = 4'd5
    } state_t;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_R    = 2'd1,
        DIR_L    = 2'd2
    } dir_t;

    // Both buttons pressed cancel out to no direction.
    function automatic dir_t decode_dir(input logic left, input logic right);
        if (right && !left) return DIR_R;
        if (left && !right) return DIR_L;
        return DIR_NONE;
    endfunction

    function automatic state_t ground_state(input dir_t d);
        case (d)
            DIR_R:   return ST_RUN_R;
            DIR_L:   return ST_RUN_L;
            default: return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/player_state_fsm_if.sv
// Per-frame control inputs and registered player outputs.
// Latency: n/a (wiring only).
// Backpressure: none; the frame tick paces everything.
interface player_state_fsm_if;
    import player_pkg::*;

    logic                       frame_tick;
    logic                       start;
    logic                       up;
    logic                       left;
    logic                       right;
    logic                       on_ground;
    logic [STATE_W-1:0]         curr_state;
    logic [FRAME_W-1:0]         animation_frame_num;
    logic signed [SPEED_W-1:0]  y_speed;
    logic                       facing_left;

    modport master (
        output frame_tick, start, up, left, right, on_ground,
        input  curr_state, animation_frame_num, y_speed, facing_left
    );

    modport slave (
        input  frame_tick, start, up, left, right, on_ground,
        output curr_state, animation_frame_num, y_speed, facing_left
    );

endinterface

// File: rtl/player_state_fsm_anim.sv
// Animation frame counter: divides frame ticks, steps a wrapping frame index.
// Latency: 1 cycle from tick.
// Backpressure: none; clear overrides the step on the same tick.
module anim_frame_counter
    import player_pkg::*;
#(
    parameter int FRAME_DIV  = 6,
    parameter int NUM_FRAMES = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               clear,
    output logic [FRAME_W-1:0] frame_num
);

    localparam logic [5:0]         DIV_LAST   = 6'(FRAME_DIV - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(NUM_FRAMES - 1);

    logic [5:0] div_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt   <= '0;
            frame_num <= '0;
        end else if (tick) begin
            if (clear) begin
                div_cnt   <= '0;
                frame_num <= '0;
            end else if (div_cnt == DIV_LAST) begin
                div_cnt   <= '0;
                frame_num <= (frame_num == FRAME_LAST) ? '0 : frame_num + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/player_state_fsm.sv
// Frame-locked player state machine: state, vertical speed, facing, animation.
// Latency: 1 cycle from frame_tick; all outputs registered.
// Backpressure: none; inputs are sampled only on tick cycles.
module player_state_fsm
    import player_pkg::*;
#(
    parameter int FRAME_DIV  = 6,
    parameter int NUM_FRAMES = 8,
    parameter int JUMP_SPEED = 7
) (
    input  logic               clk,
    input  logic               rst,
    player_state_fsm_if.slave  bus
);

    localparam logic signed [SPEED_W-1:0] JUMP_V = SPEED_W'(JUMP_SPEED);
    localparam logic signed [SPEED_W-1:0] ZERO_V = '0;
    localparam logic signed [SPEED_W-1:0] ONE_V  = 4'sd1;

    state_t                    state_q, state_d;
    logic signed [SPEED_W-1:0] y_q, y_d;
    logic                      face_q, face_d;
    logic                      armed_q, armed_d;
    logic                      launch;
    logic                      state_chg;
    dir_t                      dir;

    always_comb begin
        dir     = decode_dir(bus.left, bus.right);
        state_d = state_q;
        y_d     = y_q;
        face_d  = face_q;
        armed_d = armed_q;
        launch  = 1'b0;

        if (bus.frame_tick) begin
            case (state_q)
                ST_LEVEL_1_BEGIN: begin
                    if (bus.start) state_d = ST_IDLE;
                end
                ST_IDLE, ST_RUN_R, ST_RUN_L: begin
                    if (!bus.on_ground) begin
                        state_d = ST_FALL;
                        y_d     = ZERO_V;
                    end else if (bus.up && armed_q) begin
                        state_d = ST_JUMP;
                        y_d     = JUMP_V;
                        launch  = 1'b1;
                    end else begin
                        state_d = ground_state(dir);
                    end
                end
                ST_JUMP: begin
                    y_d = y_q - ONE_V;
                    if (y_d <= ZERO_V) state_d = ST_FALL;
                end
                ST_FALL: begin
                    // Only a downward-moving player can land; y=0 at the apex keeps falling.
                    if (bus.on_ground && (y_q < ZERO_V)) begin
                        y_d     = ZERO_V;
                        state_d = ground_state(dir);
                    end else if (y_q != SPEED_MIN) begin
                        y_d = y_q - ONE_V;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (state_q != ST_LEVEL_1_BEGIN) begin
                if (dir == DIR_L)      face_d = 1'b1;
                else if (dir == DIR_R) face_d = 1'b0;
            end

            // Re-arming needs a released button, so a held up never relaunches on landing.
            if (launch)       armed_d = 1'b0;
            else if (!bus.up) armed_d = 1'b1;
        end
    end

    assign state_chg = (state_d != state_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_LEVEL_1_BEGIN;
            y_q     <= ZERO_V;
            face_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            face_q  <= face_d;
            armed_q <= armed_d;
        end
    end

    anim_frame_counter #(
        .FRAME_DIV  (FRAME_DIV),
        .NUM_FRAMES (NUM_FRAMES)
    ) u_anim (
        .clk       (clk),
        .rst       (rst),
        .tick      (bus.frame_tick),
        .clear     (state_chg),
        .frame_num (bus.animation_frame_num)
    );

    assign bus.curr_state  = state_q;
    assign bus.y_speed     = y_q;
    assign bus.facing_left = face_q;

endmodule

// File: tb/tb_player_state_fsm.sv
// Directed scenarios then randomized ticks, checked against an integer reference model.
module tb_player_state_fsm;
    import player_pkg::*;

    localparam int FD = 6;
    localparam int NF = 8;
    localparam int JS = 7;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    player_state_fsm_if bus();

    player_state_fsm #(.FRAME_DIV(FD), .NUM_FRAMES(NF), .JUMP_SPEED(JS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: 0 title, 1 idle, 2 run right, 3 run left, 4 jump, 5 fall
    int m_state = 0, m_y = 0, m_div = 0, m_frame = 0;
    bit m_face = 0, m_armed = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int dir_target(bit l, bit r);
        if (r && !l) return 2;
        if (l && !r) return 3;
        return 1;
    endfunction

    function void model_update();
        int ns, ny;
        bit dl, dr, launch;
        if (rst) begin
            m_state = 0; m_y = 0; m_div = 0; m_frame = 0; m_face = 0; m_armed = 0;
            return;
        end
        if (!bus.frame_tick) return;
        dl = bus.left && !bus.right;
        dr = bus.right && !bus.left;
        ns = m_state; ny = m_y; launch = 0;
        if (m_state == 0) begin
            if (bus.start) ns = 1;
        end else if (m_state >= 1 && m_state <= 3) begin
            if (!bus.on_ground) begin ns = 5; ny = 0; end
            else if (bus.up && m_armed) begin ns = 4; ny = JS; launch = 1; end
            else ns = dir_target(bus.left, bus.right);
        end else if (m_state == 4) begin
            ny = m_y - 1;
            if (ny <= 0) ns = 5;
        end else if (m_state == 5) begin
            if (bus.on_ground && m_y < 0) begin ny = 0; ns = dir_target(bus.left, bus.right); end
            else ny = (m_y - 1 < -8) ? -8 : m_y - 1;
        end else begin
            ns = 1;
        end
        if (m_state != 0) begin
            if (dl) m_face = 1;
            else if (dr) m_face = 0;
        end
        if (launch) m_armed = 0;
        else if (!bus.up) m_armed = 1;
        if (ns != m_state) begin
            m_div = 0; m_frame = 0;
        end else if (m_div == FD - 1) begin
            m_div = 0; m_frame = (m_frame + 1) % NF;
        end else begin
            m_div++;
        end
        m_state = ns; m_y = ny;
    endfunction

    task automatic step(input bit t, input bit s, input bit u, input bit l,
                        input bit r, input bit g, input bit rs);
        rst = rs; bus.frame_tick = t; bus.start = s;
        bus.up = u; bus.left = l; bus.right = r; bus.on_ground = g;
        @(posedge clk);
        model_update();
        #1;
        chk("model_state", int'(bus.curr_state), m_state);
        chk("model_frame", int'(bus.animation_frame_num), m_frame);
        chk("model_yspeed", int'($signed(bus.y_speed)), m_y);
        chk("model_facing", int'(bus.facing_left), int'(m_face));
    endtask

    task automatic tk(input bit u, input bit l, input bit r, input bit g);
        step(1'b1, 1'b0, u, l, r, g, 1'b0);
    endtask

    initial begin
        // Reset values
        step(0, 0, 0, 0, 0, 0, 1);
        chk("rst_state", int'(bus.curr_state), 0);
        chk("rst_frame", int'(bus.animation_frame_num), 0);
        chk("rst_yspeed", int'($signed(bus.y_speed)), 0);
        chk("rst_facing", int'(bus.facing_left), 0);

        // Title exit: start between ticks is ignored
        repeat (3) step(0, 1, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 1, 0);
        chk("title_hold", int'(bus.curr_state), 0);
        step(1, 1, 0, 0, 0, 1, 0);
        chk("title_exit", int'(bus.curr_state), 1);
        chk("title_frame", int'(bus.animation_frame_num), 0);

        // Run right and animation stepping
        tk(0, 0, 1, 1);
        chk("run_r", int'(bus.curr_state), 2);
        repeat (5) tk(0, 0, 1, 1);
        chk("anim_before_step", int'(bus.animation_frame_num), 0);
        tk(0, 0, 1, 1);
        chk("anim_step", int'(bus.animation_frame_num), 1);
        repeat (41) tk(0, 0, 1, 1);
        chk("anim_last", int'(bus.animation_frame_num), 7);
        tk(0, 0, 1, 1);
        chk("anim_wrap", int'(bus.animation_frame_num), 0);
        tk(0, 1, 1, 1);
        chk("both_dirs_idle", int'(bus.curr_state), 1);

        // Jump arc, fall saturation, landing with up held
        tk(1, 0, 0, 1);
        chk("jump_launch_state", int'(bus.curr_state), 4);
        chk("jump_launch_speed", int'($signed(bus.y_speed)), 7);
        for (int k = 6; k >= 1; k--) begin
            tk(1, 0, 0, 0);
            chk("jump_arc", int'($signed(bus.y_speed)), k);
        end
        tk(1, 0, 0, 0);
        chk("apex_state", int'(bus.curr_state), 5);
        chk("apex_speed", int'($signed(bus.y_speed)), 0);
        for (int k = 1; k <= 10; k++) begin
            tk(1, 0, 0, 0);
            chk("fall_speed", int'($signed(bus.y_speed)), (k > 8) ? -8 : -k);
        end
        tk(1, 0, 0, 1);
        chk("land_state", int'(bus.curr_state), 1);
        chk("land_speed", int'($signed(bus.y_speed)), 0);

        // No relaunch while up stays held; release then press launches
        tk(1, 0, 0, 1);
        chk("no_rejump", int'(bus.curr_state), 1);
        tk(0, 0, 0, 1);
        tk(1, 0, 0, 1);
        chk("rejump", int'(bus.curr_state), 4);
        repeat (3) tk(0, 0, 0, 0);
        chk("midair_speed", int'($signed(bus.y_speed)), 4);

        // Reset wins over a simultaneous tick
        step(1, 0, 1, 1, 0, 1, 1);
        chk("midair_rst_state", int'(bus.curr_state), 0);
        chk("midair_rst_speed", int'($signed(bus.y_speed)), 0);
        chk("midair_rst_frame", int'(bus.animation_frame_num), 0);
        chk("midair_rst_facing", int'(bus.facing_left), 0);

        // Edge walk-off while running left
        step(1, 1, 0, 0, 0, 1, 0);
        tk(0, 1, 0, 1);
        chk("run_l", int'(bus.curr_state), 3);
        tk(0, 1, 0, 0);
        chk("walkoff_state", int'(bus.curr_state), 5);
        chk("walkoff_speed", int'($signed(bus.y_speed)), 0);
        chk("walkoff_facing", int'(bus.facing_left), 1);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 99) < 60, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 299) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
